// File: rtl/scan_line_sequencer_pkg.sv
// rtl/scan_line_sequencer_pkg.sv - shared types and helpers for the scan line sequencer
package scan_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRE    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_ACQ     = 3'd3,
        ST_READOUT = 3'd4
    } state_t;

    // Ceiling of the AFE gain code; the TGC ramp saturates here.
    localparam logic [5:0] GAIN_MAX = 6'd63;

    // Decimation factor D = 1 << zoom (1, 2, 4 or 8).
    function automatic logic [3:0] zoom_to_d(input logic [1:0] zoom);
        return 4'd1 << zoom;
    endfunction

endpackage

// File: rtl/scan_line_sequencer_if.sv
// rtl/scan_line_sequencer_if.sv - command, AFE, line buffer and readout signals of the sequencer
interface scan_line_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              Start_Req;
    logic [7:0]        Line_Num;
    logic [1:0]        Zoom;
    logic [5:0]        Gain;
    logic              Rd_Done;
    logic [DATA_W-1:0] Adc_Data;

    logic              Tx_Pulse;
    logic [6:0]        Tx_Line;
    logic [5:0]        Gain_Out;
    logic              Buf_Wr_En;
    logic [ADDR_W-1:0] Buf_Wr_Addr;
    logic [DATA_W-1:0] Buf_Wr_Data;
    logic              Envelop;
    logic              Line_Done;
    logic              Busy;
    logic              Err_Req;

    // Command/readout/ADC side: drives requests and samples, observes results.
    modport master (
        output Start_Req, Line_Num, Zoom, Gain, Rd_Done, Adc_Data,
        input  Tx_Pulse, Tx_Line, Gain_Out, Buf_Wr_En, Buf_Wr_Addr, Buf_Wr_Data,
               Envelop, Line_Done, Busy, Err_Req
    );

    // Sequencer side.
    modport slave (
        input  Start_Req, Line_Num, Zoom, Gain, Rd_Done, Adc_Data,
        output Tx_Pulse, Tx_Line, Gain_Out, Buf_Wr_En, Buf_Wr_Addr, Buf_Wr_Data,
               Envelop, Line_Done, Busy, Err_Req
    );

endinterface

// File: rtl/scan_line_sequencer_acq_addr_gen.sv
// rtl/scan_line_sequencer_acq_addr_gen.sv - decimation and line buffer address counters
module acq_addr_gen #(
    parameter int SAMPLES = 512,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [2:0]        dec_max,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [2:0]        dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Decimation count runs 0..D-1; address advances after every strobe and wraps naturally.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        addr_d    = addr_q;
        if (clear) begin
            dec_cnt_d = '0;
            addr_d    = '0;
        end else if (en) begin
            dec_cnt_d = (dec_cnt_q == dec_max) ? 3'd0 : dec_cnt_q + 3'd1;
            if (dec_cnt_q == 3'd0) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_q <= '0;
            addr_q    <= '0;
        end else begin
            dec_cnt_q <= dec_cnt_d;
            addr_q    <= addr_d;
        end
    end

    assign wr_stb = en && (dec_cnt_q == 3'd0);
    assign addr   = addr_q;
    assign last   = wr_stb && (addr_q == ADDR_W'(SAMPLES - 1));

endmodule

// File: rtl/scan_line_sequencer.sv
// rtl/scan_line_sequencer.sv - per-line fire/wait/acquire/readout controller; optional TGC ramp under TGC_RAMP_EN
module scan_line_sequencer #(
    parameter int SAMPLES   = 512,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int LINES     = 128,
    parameter int PULSE_CYC = 4,
    parameter int DELAY_CYC = 32,
    parameter int TGC_STEP  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    scan_line_sequencer_if.slave bus
);
    import scan_seq_pkg::*;

    if (PULSE_CYC < 1) begin : g_bad_pulse
        $error("PULSE_CYC must be at least 1");
    end
    if (DELAY_CYC < 1) begin : g_bad_delay
        $error("DELAY_CYC must be at least 1");
    end
    if (TGC_STEP < 1) begin : g_bad_tgc_step
        $error("TGC_STEP must be at least 1");
    end

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        tx_pulse_q, tx_pulse_d;
    logic [6:0]  tx_line_q, tx_line_d;
    logic [2:0]  dec_max_q, dec_max_d;
    logic [5:0]  gain_out_q, gain_out_d;
    logic        envelop_q, envelop_d;
    logic        line_done_q, line_done_d;
    logic        err_q, err_d;

    logic              accept;
    logic              can_accept;
    logic              acq_clear;
    logic              acq_en;
    logic              wr_stb;
    logic              last_wr;
    logic [ADDR_W-1:0] wr_addr;

`ifdef TGC_RAMP_EN
    logic [15:0] tgc_cnt_q, tgc_cnt_d;
`endif

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_READOUT);
    assign accept     = bus.Start_Req && can_accept && (int'(bus.Line_Num) < LINES);
    assign acq_en     = (state_q == ST_ACQ);

    acq_addr_gen #(
        .SAMPLES (SAMPLES),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk     (Clk),
        .rst     (Rst),
        .clear   (acq_clear),
        .en      (acq_en),
        .dec_max (dec_max_q),
        .wr_stb  (wr_stb),
        .addr    (wr_addr),
        .last    (last_wr)
    );

    // Next-state, per-line latches, error flag and registered handshake outputs.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tx_line_d   = tx_line_q;
        dec_max_d   = dec_max_q;
        gain_out_d  = gain_out_q;
        err_d       = err_q;
        acq_clear   = 1'b0;
`ifdef TGC_RAMP_EN
        tgc_cnt_d   = tgc_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (timer_q == 16'(PULSE_CYC - 1)) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (timer_q == 16'(DELAY_CYC - 1)) begin
                    state_d   = ST_ACQ;
                    timer_d   = '0;
                    acq_clear = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_ACQ: begin
                if (last_wr) begin
                    state_d = ST_READOUT;
                end
            end
            ST_READOUT: begin
                // A new request outranks the readout-done pulse and releases the buffer implicitly.
                if (accept) begin
                    state_d = ST_FIRE;
                end else if (bus.Rd_Done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            timer_d    = '0;
            tx_line_d  = bus.Line_Num[6:0];
            dec_max_d  = 3'(zoom_to_d(bus.Zoom) - 4'd1);
            gain_out_d = bus.Gain;
`ifdef TGC_RAMP_EN
            tgc_cnt_d  = '0;
`endif
        end

        if (bus.Start_Req && !accept) begin
            err_d = 1'b1;
        end

`ifdef TGC_RAMP_EN
        // Every TGC_STEP writes bump the gain one code, held at the ceiling.
        if (wr_stb) begin
            if (tgc_cnt_q == 16'(TGC_STEP - 1)) begin
                tgc_cnt_d = '0;
                if (gain_out_q != GAIN_MAX) begin
                    gain_out_d = gain_out_q + 6'd1;
                end
            end else begin
                tgc_cnt_d = tgc_cnt_q + 16'd1;
            end
        end
`endif

        tx_pulse_d  = (state_d == ST_FIRE);
        envelop_d   = (state_d != ST_READOUT);
        line_done_d = (state_d == ST_READOUT) && (state_q != ST_READOUT);
    end

    // State and output registers; reset aborts a line and returns the buffer to acquisition.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            tx_pulse_q  <= 1'b0;
            tx_line_q   <= '0;
            dec_max_q   <= '0;
            gain_out_q  <= '0;
            envelop_q   <= 1'b1;
            line_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tx_pulse_q  <= tx_pulse_d;
            tx_line_q   <= tx_line_d;
            dec_max_q   <= dec_max_d;
            gain_out_q  <= gain_out_d;
            envelop_q   <= envelop_d;
            line_done_q <= line_done_d;
            err_q       <= err_d;
        end
    end

`ifdef TGC_RAMP_EN
    // TGC write counter register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            tgc_cnt_q <= '0;
        end else begin
            tgc_cnt_q <= tgc_cnt_d;
        end
    end
`endif

    assign bus.Tx_Pulse    = tx_pulse_q;
    assign bus.Tx_Line     = tx_line_q;
    assign bus.Gain_Out    = gain_out_q;
    assign bus.Buf_Wr_En   = wr_stb;
    assign bus.Buf_Wr_Addr = wr_addr;
    assign bus.Buf_Wr_Data = bus.Adc_Data;
    assign bus.Envelop     = envelop_q;
    assign bus.Line_Done   = line_done_q;
    assign bus.Busy        = (state_q == ST_FIRE) || (state_q == ST_WAIT) || (state_q == ST_ACQ);
    assign bus.Err_Req     = err_q;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// tb/tb_scan_line_sequencer.sv - directed self-checking bench for scan_line_sequencer
module tb_scan_line_sequencer;

    localparam int SAMPLES   = 512;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 8;
    localparam int LINES     = 128;
    localparam int PULSE_CYC = 4;
    localparam int DELAY_CYC = 32;
    localparam int TGC_STEP  = 16;

    logic Clk;
    logic Rst;
    int   vectors;
    int   miscompares;
    logic err_exp;

    scan_line_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    scan_line_sequencer #(
        .SAMPLES   (SAMPLES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINES     (LINES),
        .PULSE_CYC (PULSE_CYC),
        .DELAY_CYC (DELAY_CYC),
        .TGC_STEP  (TGC_STEP)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Packed view: tx(1) line(7) gain(6) en(1) addr(9) env(1) done(1) busy(1) err(1)
    task automatic test_reset();
        logic [27:0] obs;
        logic [27:0] exp;
        Rst = 1'b1;
        bus.Start_Req = 1'b0; bus.Line_Num = '0; bus.Zoom = '0; bus.Gain = '0;
        bus.Rd_Done = 1'b0; bus.Adc_Data = '0;
        err_exp = 1'b0;
        step();
        step();
        exp = {1'b0, 7'd0, 6'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        obs = {bus.Tx_Pulse, bus.Tx_Line, bus.Gain_Out, bus.Buf_Wr_En, bus.Buf_Wr_Addr,
               bus.Envelop, bus.Line_Done, bus.Busy, bus.Err_Req};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_in: got %h expected %h", obs, exp);
        end
        Rst = 1'b0;
        step();
        step();
        obs = {bus.Tx_Pulse, bus.Tx_Line, bus.Gain_Out, bus.Buf_Wr_En, bus.Buf_Wr_Addr,
               bus.Envelop, bus.Line_Done, bus.Busy, bus.Err_Req};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs, exp);
        end
    endtask

    // Request a line at cycle 0 and check every output each cycle up to READOUT entry.
    task automatic test_line(input string name, input logic [7:0] ln, input logic [1:0] zm,
                             input logic [5:0] gn, input logic rd_too, input int poke_c);
        int          d;
        int          first;
        int          last_w;
        int          end_c;
        int          wcount;
        int          g;
        logic        e_tx;
        logic        e_en;
        logic        e_env;
        logic        e_done;
        logic        e_busy;
        logic [5:0]  e_gain;
        logic [7:0]  adc;
        logic [27:0] obs;
        logic [27:0] exp;
        d      = 1 << zm;
        first  = PULSE_CYC + DELAY_CYC + 1;
        last_w = first + (SAMPLES - 1) * d;
        end_c  = last_w + 1;
        wcount = 0;
        bus.Start_Req = 1'b1;
        bus.Line_Num  = ln;
        bus.Zoom      = zm;
        bus.Gain      = gn;
        bus.Rd_Done   = rd_too;
        step();
        bus.Rd_Done   = 1'b0;
        for (int c = 1; c <= end_c; c++) begin
            bus.Start_Req = (c == poke_c);
            bus.Line_Num  = 8'd3;
            adc = 8'((c * 37 + 11) % 256);
            bus.Adc_Data = adc;
            #1;
            e_tx   = (c <= PULSE_CYC);
            e_en   = (c >= first) && (c <= last_w) && (((c - first) % d) == 0);
            e_env  = (c != end_c);
            e_done = (c == end_c);
            e_busy = (c < end_c);
            e_gain = gn;
`ifdef TGC_RAMP_EN
            g = int'(gn) + wcount / TGC_STEP;
            e_gain = (g > 63) ? 6'd63 : 6'(g);
`else
            g = 0;
`endif
            exp = {e_tx, ln[6:0], e_gain, e_en, 9'(wcount), e_env, e_done, e_busy, err_exp};
            obs = {bus.Tx_Pulse, bus.Tx_Line, bus.Gain_Out, bus.Buf_Wr_En, bus.Buf_Wr_Addr,
                   bus.Envelop, bus.Line_Done, bus.Busy, bus.Err_Req};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h (g=%0d)", name, c, obs, exp, g);
            end
            if (e_en) begin
                vectors++;
                if (bus.Buf_Wr_Data !== adc) begin
                    miscompares++;
                    $display("FAIL %s_data cycle %0d: got %h expected %h", name, c, bus.Buf_Wr_Data, adc);
                end
                wcount++;
            end
            if (c == poke_c) begin
                err_exp = 1'b1;
            end
            step();
        end
        bus.Start_Req = 1'b0;
    endtask

    task automatic test_rd_done();
        vectors++;
        if ({bus.Envelop, bus.Line_Done, bus.Busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL readout_hold: got %b expected 000", {bus.Envelop, bus.Line_Done, bus.Busy});
        end
        bus.Rd_Done = 1'b1;
        step();
        bus.Rd_Done = 1'b0;
        vectors++;
        if ({bus.Envelop, bus.Busy, bus.Tx_Pulse} !== 3'b100) begin
            miscompares++;
            $display("FAIL rd_done_idle: got %b expected 100", {bus.Envelop, bus.Busy, bus.Tx_Pulse});
        end
        bus.Rd_Done = 1'b1;
        step();
        bus.Rd_Done = 1'b0;
        step();
        vectors++;
        if ({bus.Envelop, bus.Busy, bus.Err_Req} !== {2'b10, err_exp}) begin
            miscompares++;
            $display("FAIL rd_done_in_idle: got %b expected %b", {bus.Envelop, bus.Busy, bus.Err_Req}, {2'b10, err_exp});
        end
    endtask

    task automatic test_invalid_line();
        bus.Start_Req = 1'b1;
        bus.Line_Num  = 8'd200;
        step();
        bus.Start_Req = 1'b0;
        err_exp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bus.Tx_Pulse, bus.Busy, bus.Err_Req, bus.Envelop} !== 4'b0011) begin
                miscompares++;
                $display("FAIL invalid_line step %0d: got %b expected 0011", i,
                         {bus.Tx_Pulse, bus.Busy, bus.Err_Req, bus.Envelop});
            end
            step();
        end
    endtask

    task automatic test_reset_mid_line();
        bus.Start_Req = 1'b1;
        bus.Line_Num  = 8'd9;
        bus.Zoom      = 2'd0;
        bus.Gain      = 6'd20;
        step();
        bus.Start_Req = 1'b0;
        for (int c = 1; c < 136; c++) begin
            step();
        end
        vectors++;
        if ({bus.Buf_Wr_En, bus.Buf_Wr_Addr, bus.Envelop} !== {1'b1, 9'd99, 1'b1}) begin
            miscompares++;
            $display("FAIL midline_100th_write: got %h expected %h",
                     {bus.Buf_Wr_En, bus.Buf_Wr_Addr, bus.Envelop}, {1'b1, 9'd99, 1'b1});
        end
        Rst = 1'b1;
        #1;
        vectors++;
        if ({bus.Buf_Wr_En, bus.Tx_Pulse, bus.Envelop, bus.Busy} !== 4'b0010) begin
            miscompares++;
            $display("FAIL midline_async_abort: got %b expected 0010",
                     {bus.Buf_Wr_En, bus.Tx_Pulse, bus.Envelop, bus.Busy});
        end
        step();
        step();
        Rst = 1'b0;
        err_exp = 1'b0;
        step();
        vectors++;
        if ({bus.Busy, bus.Buf_Wr_Addr, bus.Envelop, bus.Err_Req, bus.Gain_Out, bus.Tx_Line}
            !== {1'b0, 9'd0, 1'b1, 1'b0, 6'd0, 7'd0}) begin
            miscompares++;
            $display("FAIL midline_after_release: got %h expected %h",
                     {bus.Busy, bus.Buf_Wr_Addr, bus.Envelop, bus.Err_Req, bus.Gain_Out, bus.Tx_Line},
                     {1'b0, 9'd0, 1'b1, 1'b0, 6'd0, 7'd0});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_line("basic_z0", 8'd5, 2'd0, 6'd60, 1'b0, -1);
        test_rd_done();
        test_invalid_line();
        test_line("zoom3_busy_poke", 8'd127, 2'd3, 6'd10, 1'b0, 200);
        test_line("start_with_rd", 8'd0, 2'd1, 6'd33, 1'b1, -1);
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
